// File: rtl/cabac_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cabac_dec_pkg
// Description : Shared constants and helpers for the CABAC bin decoder.
//               RANGE_INIT/RANGE_W/VALUE_W/EP_W size the arithmetic state;
//               lps_shift() gives the renormalisation shift for an LPS range.
// Revision    : 1.0 - initial release
// ============================================================================
package cabac_dec_pkg;

  localparam int RANGE_INIT = 510;
  localparam int RANGE_W    = 9;
  localparam int VALUE_W    = 16;
  localparam int EP_W       = 17;

  // Shift that brings an LPS range (4..236) back into 256..511,
  // i.e. 8 - floor(log2(lps)).
  function automatic logic [2:0] lps_shift(input logic [7:0] lps);
    logic [2:0] n;
    if (lps[7])      n = 3'd1;
    else if (lps[6]) n = 3'd2;
    else if (lps[5]) n = 3'd3;
    else if (lps[4]) n = 3'd4;
    else if (lps[3]) n = 3'd5;
    else             n = 3'd6;
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cabac_lps_calc.sv
`default_nettype none
// ============================================================================
// Module      : cabac_lps_calc
// Description : Combinational LPS sub-range and renormalisation shift.
//   pState_in   [7:0] probability state, bit 7 = MPS
//   range_q     [8:0] current arithmetic range
//   lps_range   [7:0] LPS sub-range, 4..236
//   lps_shift_n [2:0] shift that renormalises lps_range
// Revision    : 1.0 - initial release
// ============================================================================
module cabac_lps_calc
  import cabac_dec_pkg::*;
(
  input  logic [7:0]         pState_in,
  input  logic [RANGE_W-1:0] range_q,
  output logic [7:0]         lps_range,
  output logic [2:0]         lps_shift_n
);

  // Folding the state around the MPS bit always clears bit 7, so only
  // q[6:2] (i.e. q>>2) matters: at most 31 * 15 = 465, which fits 9 bits.
  logic [4:0] w_q_hi;
  logic [3:0] w_range_hi;
  logic [8:0] w_prod;
  logic       w_unused;

  assign w_q_hi     = pState_in[7] ? ~pState_in[6:2] : pState_in[6:2];
  assign w_range_hi = range_q[8:5];
  assign w_prod     = {4'b0, w_q_hi} * {5'b0, w_range_hi};
  assign lps_range  = w_prod[8:1] + 8'd4;
  assign lps_shift_n = lps_shift(lps_range);

  assign w_unused = ^{pState_in[1:0], range_q[4:0], w_prod[0]};

endmodule
`default_nettype wire

// File: rtl/cabac_bin_decoder.sv
`default_nettype none
// ============================================================================
// Module      : cabac_bin_decoder
// Description : CABAC arithmetic bin decoder core. Decodes one regular bin or
//               BIN_WIDTH bypass bins per clock; byte insertion is done by an
//               external controller that feeds the offset back in.
//   clk, reset                synchronous active-high reset
//   bypass                    1 = bypass bins, 0 = regular (context) bin
//   pState_in          [7:0]  probability state, bit 7 = MPS
//   m_value_binRE_in   [15:0] next offset, loaded every cycle
//   m_value_binEP0_in  [16:0] doubled offset (+ byte) for bypass bin 0
//   bin                [BIN_WIDTH-1:0] decoded bins, bin k on bit k
//   numBits            [2:0]  renormalisation shift (regular only)
//   m_value_binRE_out  [15:0] updated offset before byte insertion
//   m_value_binEP0_out [16:0] {value_q, 1'b0}
//   mps_renorm, lps           regular-bin path flags
//   range_dbg          [8:0]  range_q, only with CABAC_DEC_RANGE_OBS_EN
// Optional    : define CABAC_DEC_RANGE_OBS_EN to expose range_dbg.
// Revision    : 1.0 - initial release
// ============================================================================
module cabac_bin_decoder
  import cabac_dec_pkg::*;
#(
  parameter int BIN_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bypass,
  input  logic [7:0]           pState_in,
  input  logic [VALUE_W-1:0]   m_value_binRE_in,
  input  logic [EP_W-1:0]      m_value_binEP0_in,
  output logic [BIN_WIDTH-1:0] bin,
  output logic [2:0]           numBits,
  output logic [VALUE_W-1:0]   m_value_binRE_out,
  output logic [EP_W-1:0]      m_value_binEP0_out,
  output logic                 mps_renorm,
  output logic                 lps
`ifdef CABAC_DEC_RANGE_OBS_EN
  ,
  output logic [RANGE_W-1:0]   range_dbg
`endif
);

  logic [RANGE_W-1:0] r_range;
  logic [VALUE_W-1:0] r_value;
  logic [RANGE_W-1:0] w_range_nxt;

  logic [7:0]         w_lps;
  logic [2:0]         w_n;
  logic [RANGE_W-1:0] w_rmps;
  logic [VALUE_W-1:0] w_scaled;
  logic               w_is_mps;
  logic [VALUE_W-1:0] w_lps_value;
  logic [RANGE_W-1:0] w_lps_range;

  cabac_lps_calc u_lps_calc (
    .pState_in   (pState_in),
    .range_q     (r_range),
    .lps_range   (w_lps),
    .lps_shift_n (w_n)
  );

  // Regular path: rMPS <= 506, so rMPS<<7 fits the 16-bit offset.
  assign w_rmps      = r_range - {1'b0, w_lps};
  assign w_scaled    = {w_rmps, 7'b0};
  assign w_is_mps    = r_value < w_scaled;
  assign w_lps_value = (r_value - w_scaled) << w_n;
  assign w_lps_range = {1'b0, w_lps} << w_n;

  // Bypass chain: each stage compares against range<<7 and passes the
  // doubled residue to the next stage.
  logic [EP_W-1:0]      w_scaled_rng;
  logic [EP_W-1:0]      w_v   [BIN_WIDTH];
  logic [EP_W-1:0]      w_res [BIN_WIDTH];
  logic [BIN_WIDTH-1:0] w_bb;

  assign w_scaled_rng = {1'b0, r_range, 7'b0};

  for (genvar k = 0; k < BIN_WIDTH; k++) begin : g_bypass
    if (k == 0) begin : g_first
      assign w_v[k] = m_value_binEP0_in;
    end else begin : g_next
      assign w_v[k] = w_res[k-1] << 1;
    end
    assign w_bb[k]  = w_v[k] >= w_scaled_rng;
    assign w_res[k] = w_bb[k] ? (w_v[k] - w_scaled_rng) : w_v[k];
  end

  always_comb begin
    bin               = '0;
    numBits           = 3'd0;
    mps_renorm        = 1'b0;
    lps               = 1'b0;
    m_value_binRE_out = r_value;
    w_range_nxt       = r_range;
    if (bypass) begin
      bin               = w_bb;
      m_value_binRE_out = VALUE_W'(w_res[BIN_WIDTH-1]);
    end else if (w_is_mps) begin
      bin[0] = pState_in[7];
      if (w_rmps[8]) begin
        w_range_nxt = w_rmps;
      end else begin
        w_range_nxt       = {w_rmps[7:0], 1'b0};
        numBits           = 3'd1;
        mps_renorm        = 1'b1;
        m_value_binRE_out = {r_value[14:0], 1'b0};
      end
    end else begin
      bin[0]            = ~pState_in[7];
      lps               = 1'b1;
      numBits           = w_n;
      w_range_nxt       = w_lps_range;
      m_value_binRE_out = w_lps_value;
    end
  end

  assign m_value_binEP0_out = {r_value, 1'b0};

`ifdef CABAC_DEC_RANGE_OBS_EN
  assign range_dbg = r_range;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_range <= RANGE_W'(RANGE_INIT);
      r_value <= '0;
    end else begin
      r_range <= w_range_nxt;
      r_value <= m_value_binRE_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cabac_bin_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cabac_bin_decoder
// Description : Scoreboard bench for cabac_bin_decoder (BIN_WIDTH = 3).
//               Expected outputs come from an integer-arithmetic model of the
//               decoding rules; a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cabac_bin_decoder;

  localparam int BW = 3;

  typedef struct packed {
    logic [3:0]  bin;
    logic [2:0]  nb;
    logic [15:0] re;
    logic [16:0] ep0;
    logic        mr;
    logic        lp;
    logic [8:0]  rng;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          bypass = 1'b0;
  logic [7:0]    pState_in = 8'h00;
  logic [15:0]   m_value_binRE_in = 16'h0;
  logic [16:0]   m_value_binEP0_in = 17'h0;
  logic [BW-1:0] bin;
  logic [2:0]    numBits;
  logic [15:0]   m_value_binRE_out;
  logic [16:0]   m_value_binEP0_out;
  logic          mps_renorm;
  logic          lps;
`ifdef CABAC_DEC_RANGE_OBS_EN
  logic [8:0]    range_dbg;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  int   m_rng = 510;
  int   m_val = 0;

  always #5 clk = ~clk;

  cabac_bin_decoder #(.BIN_WIDTH(BW)) dut (
    .clk                (clk),
    .reset              (reset),
    .bypass             (bypass),
    .pState_in          (pState_in),
    .m_value_binRE_in   (m_value_binRE_in),
    .m_value_binEP0_in  (m_value_binEP0_in),
    .bin                (bin),
    .numBits            (numBits),
    .m_value_binRE_out  (m_value_binRE_out),
    .m_value_binEP0_out (m_value_binEP0_out),
    .mps_renorm         (mps_renorm),
    .lps                (lps)
`ifdef CABAC_DEC_RANGE_OBS_EN
    ,
    .range_dbg          (range_dbg)
`endif
  );

  // Reference model: arithmetic decoding rules in plain integers.
  function automatic void ref_model(input int rng, input int val, input int ps,
                                    input bit bp, input int ep,
                                    output exp_t e, output int nrng);
    int q, lr, rmps, sc, v, n;
    e     = '0;
    e.ep0 = 17'(val * 2);
    e.rng = 9'(rng);
    nrng  = rng;
    if (bp) begin
      sc = rng * 128;
      v  = ep;
      for (int k = 0; k < BW; k++) begin
        if (v >= sc) begin
          e.bin[k] = 1'b1;
          v = v - sc;
        end
        if (k < BW - 1) v = (v * 2) % 131072;
      end
      e.re = 16'(v % 65536);
    end else begin
      q    = (ps >= 128) ? 255 - ps : ps;
      lr   = ((q / 4) * (rng / 32)) / 2 + 4;
      rmps = rng - lr;
      sc   = rmps * 128;
      if (val < sc) begin
        e.bin[0] = (ps >= 128);
        if (rmps >= 256) begin
          nrng = rmps;
          e.re = 16'(val);
        end else begin
          nrng = rmps * 2;
          e.nb = 3'd1;
          e.mr = 1'b1;
          e.re = 16'((val * 2) % 65536);
        end
      end else begin
        n = 0;
        while ((lr << n) < 256) n++;
        e.bin[0] = (ps < 128);
        e.lp     = 1'b1;
        e.nb     = 3'(n);
        nrng     = lr << n;
        e.re     = 16'(((val - sc) << n) % 65536);
      end
    end
  endfunction

  function automatic exp_t mk(input logic [3:0] b, input logic [2:0] nb,
                              input logic [15:0] re, input logic [16:0] ep0,
                              input logic mr, input logic lp, input logic [8:0] rng);
    exp_t e;
    e.bin = b; e.nb = nb; e.re = re; e.ep0 = ep0; e.mr = mr; e.lp = lp; e.rng = rng;
    return e;
  endfunction

  // re_mode: 0 = drive re_given, 1 = echo the expected offset, 2 = random
  // offset that is legal for the next range.
  task automatic step(input bit rs, input bit bp, input logic [7:0] ps,
                      input int re_mode, input logic [15:0] re_given,
                      input logic [16:0] ep, input bit chk,
                      input bit hand_en, input exp_t hand);
    exp_t        e;
    int          nrng;
    logic [15:0] rin;
    ref_model(m_rng, m_val, int'(ps), bp, int'(ep), e, nrng);
    if (re_mode == 0)      rin = re_given;
    else if (re_mode == 1) rin = e.re;
    else                   rin = 16'($urandom_range(nrng * 128 - 1, 0));
    @(posedge clk);
    #1;
    reset             = rs;
    bypass            = bp;
    pState_in         = ps;
    m_value_binRE_in  = rin;
    m_value_binEP0_in = ep;
    if (chk) sb.push_back(hand_en ? hand : e);
    if (rs) begin
      m_rng = 510;
      m_val = 0;
    end else begin
      m_rng = nrng;
      m_val = int'(rin);
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("bin",        32'(bin),                32'(e.bin[BW-1:0]));
      check("numBits",    32'(numBits),            32'(e.nb));
      check("binRE_out",  32'(m_value_binRE_out),  32'(e.re));
      check("binEP0_out", 32'(m_value_binEP0_out), 32'(e.ep0));
      check("mps_renorm", 32'(mps_renorm),         32'(e.mr));
      check("lps",        32'(lps),                32'(e.lp));
`ifdef CABAC_DEC_RANGE_OBS_EN
      check("range_dbg",  32'(range_dbg),          32'(e.rng));
`endif
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          rs, bp;
    logic [7:0]  ps;
    logic [16:0] ep;
    int          mode;

    // Reset for two cycles; the second shows reset-state outputs.
    step(1, 0, 8'h00, 0, 16'h0, 17'h0, 0, 0, '0);
    step(1, 0, 8'h00, 0, 16'h0, 17'h0, 1, 1, mk(4'd0, 3'd0, 16'h0, 17'h0, 0, 0, 9'd510));
    // MPS without renorm: LPS 236, rMPS 274.
    step(0, 0, 8'h80, 0, 16'h0, 17'h0, 1, 1, mk(4'd1, 3'd0, 16'h0, 17'h0, 0, 0, 9'd510));
    // MPS with renorm: range 274 -> LPS 128, rMPS 146 -> 292.
    step(0, 0, 8'h80, 0, 16'h0, 17'h0, 1, 1, mk(4'd1, 3'd1, 16'h0, 17'h0, 1, 0, 9'd274));
    step(1, 0, 8'h00, 0, 16'h0, 17'h0, 0, 0, '0);
    // Bypass with zero offset keeps range 510 while loading value 0x8000.
    step(0, 1, 8'h00, 0, 16'h8000, 17'h0, 1, 1, mk(4'd0, 3'd0, 16'h0, 17'h0, 0, 0, 9'd510));
    // Bypass: 0x10000 >= 0xFF00 -> bin0=1, r0=0x100; then 0x200, 0x400 stay below.
    step(0, 1, 8'h00, 0, 16'hFE00, 17'h10000, 1, 1,
         mk(4'b0001, 3'd0, 16'h0400, 17'h10000, 0, 0, 9'd510));
    // LPS: LPS 4, n 6, (0xFE00-0xFD00)<<6 = 0x4000, next range 256.
    step(0, 0, 8'h00, 0, 16'h4000, 17'h0, 1, 1,
         mk(4'd1, 3'd6, 16'h4000, 17'h1FC00, 0, 1, 9'd510));
    // Reset mid-stream, then reset-state outputs again.
    step(1, 0, 8'h00, 0, 16'h1234, 17'h0, 0, 0, '0);
    step(0, 0, 8'h00, 0, 16'h0, 17'h0, 1, 1, mk(4'd0, 3'd0, 16'h0, 17'h0, 0, 0, 9'd510));
    // A renorm-sensitive MPS from the model confirms range returned to 510.
    step(0, 0, 8'h80, 1, 16'h0, 17'h0, 1, 0, '0);
    step(0, 0, 8'h80, 1, 16'h0, 17'h0, 1, 0, '0);

    for (int i = 0; i < 500; i++) begin
      rs   = ($urandom_range(59, 0) == 0);
      bp   = 1'($urandom_range(1, 0));
      ps   = 8'($urandom);
      ep   = 17'($urandom_range(m_rng * 256 - 1, 0));
      mode = $urandom_range(2, 1);
      step(rs, bp, ps, mode, 16'h0, ep, !rs, 0, '0);
    end

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
